// File: rtl/tri_hit_pipe.sv
// rtl/tri_hit_pipe.sv - pipelined point-in-triangle tester with edge sign flags
module tri_hit_pipe #(
  parameter int WIDTH     = 32,
  parameter int FRAC      = 16,
  parameter int TAG_W     = 8,
  parameter bit INCLUSIVE = 1'b0,
  parameter bit TWO_SIDED = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0][WIDTH-1:0]  v0,
  input  logic [2:0][WIDTH-1:0]  v1,
  input  logic [2:0][WIDTH-1:0]  v2,
  input  logic [2:0][WIDTH-1:0]  p_hit,
  input  logic [2:0][WIDTH-1:0]  normal,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_hit,
  output logic [2:0]             out_edge,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int DW  = WIDTH + 1;            // edge / point-offset vectors
  localparam int PPW = 2 * WIDTH + 2;        // cross-product partial products
  localparam int XDW = 2 * WIDTH + 3;        // partial-product difference
  localparam int CW  = 2 * WIDTH + 3 - FRAC; // shifted cross components
  localparam int NPW = CW + WIDTH;           // cross * normal products
  localparam int SW  = NPW + 2;              // sum of three products

  typedef logic signed [WIDTH-1:0] crd_t;
  typedef logic signed [DW-1:0]    dw_t;
  typedef logic signed [PPW-1:0]   pp_t;
  typedef logic signed [XDW-1:0]   xd_t;
  typedef logic signed [CW-1:0]    cw_t;
  typedef logic signed [NPW-1:0]   np_t;
  typedef logic signed [SW-1:0]    sw_t;

  logic             en;
  logic             run;
  crd_t             vtx [3][3];
  crd_t             pnt [3];
  crd_t             nrm [3];

  logic             s1_valid, s2_valid, s3_valid, s4_valid;
  logic [TAG_W-1:0] s1_tag, s2_tag, s3_tag, s4_tag;
  crd_t             s1_n [3];
  crd_t             s2_n [3];
  crd_t             s3_n [3];
  dw_t              s1_e [3][3];
  dw_t              s1_c [3][3];
  pp_t              s2_pp [3][3][2];
  xd_t              xdiff [3][3];
  cw_t              s3_cross [3][3];
  np_t              s4_prod [3][3];
  sw_t              check [3];
  logic [2:0]       pos, neg;
  logic             hit;

  // One global enable freezes every stage while the output is held
  assign en       = !out_valid || out_ready;
  assign in_ready = en && run;

  // Unpack the vector ports into signed coordinate arrays
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      vtx[0][k] = crd_t'(v0[k]);
      vtx[1][k] = crd_t'(v1[k]);
      vtx[2][k] = crd_t'(v2[k]);
      pnt[k]    = crd_t'(p_hit[k]);
      nrm[k]    = crd_t'(normal[k]);
    end
  end

  // Hold off acceptance until the first clock after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Valid chain and output register; reset drops every in-flight test
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      s3_valid  <= 1'b0;
      s4_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_edge  <= 3'b000;
      out_tag   <= '0;
    end else if (en) begin
      s1_valid  <= in_valid && run;
      s2_valid  <= s1_valid;
      s3_valid  <= s2_valid;
      s4_valid  <= s3_valid;
      out_valid <= s4_valid;
      out_hit   <= hit;
      out_edge  <= pos;
      out_tag   <= s4_tag;
    end
  end

  // S1: edge vectors e_i = v_(i+1) - v_i and point offsets c_i = p - v_i
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 3; k++) begin
          s1_e[i][k] <= dw_t'(vtx[(i + 1) % 3][k]) - dw_t'(vtx[i][k]);
          s1_c[i][k] <= dw_t'(pnt[k]) - dw_t'(vtx[i][k]);
        end
      end
      s1_n   <= nrm;
      s1_tag <= in_tag;
    end
  end

  // S2: partial products; component k = e[k+1]*c[k+2] - e[k+2]*c[k+1]
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 3; k++) begin
          s2_pp[i][k][0] <= pp_t'(s1_e[i][(k + 1) % 3]) * pp_t'(s1_c[i][(k + 2) % 3]);
          s2_pp[i][k][1] <= pp_t'(s1_e[i][(k + 2) % 3]) * pp_t'(s1_c[i][(k + 1) % 3]);
        end
      end
      s2_n   <= s1_n;
      s2_tag <= s1_tag;
    end
  end

  // S3 combinational: full-width difference of partial products
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) begin
        xdiff[i][k] = xd_t'(s2_pp[i][k][0]) - xd_t'(s2_pp[i][k][1]);
      end
    end
  end

  // S3: rescale cross components back to the coordinate fixed point (floor)
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 3; k++) begin
          s3_cross[i][k] <= cw_t'(xdiff[i][k] >>> FRAC);
        end
      end
      s3_n   <= s2_n;
      s3_tag <= s2_tag;
    end
  end

  // S4: project each cross product onto the plane normal, per component
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < 3; k++) begin
          s4_prod[i][k] <= np_t'(s3_cross[i][k]) * np_t'(s3_n[k]);
        end
      end
      s4_tag <= s3_tag;
    end
  end

  // S5 combinational: dot-product sums, sign classification and hit decision
  always_comb begin
    pos = 3'b000;
    neg = 3'b000;
    for (int i = 0; i < 3; i++) begin
      check[i] = sw_t'(s4_prod[i][0]) + sw_t'(s4_prod[i][1]) + sw_t'(s4_prod[i][2]);
      if (INCLUSIVE) begin
        pos[i] = !check[i][SW-1];
        neg[i] = check[i][SW-1] || (check[i] == '0);
      end else begin
        pos[i] = !check[i][SW-1] && (check[i] != '0);
        neg[i] = check[i][SW-1];
      end
    end
    hit = TWO_SIDED ? ((&pos) || (&neg)) : (&pos);
  end

endmodule

// File: tb/tb_tri_hit_pipe.sv
// tb/tb_tri_hit_pipe.sv - directed bench for tri_hit_pipe (strict and inclusive/two-sided builds)
module tb_tri_hit_pipe;
  localparam int W = 32;
  localparam logic [W-1:0] ONE  = 32'h0001_0000;
  localparam logic [W-1:0] HALF = 32'h0000_8000;
  localparam logic [W-1:0] QTR  = 32'h0000_4000;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            out_ready;
  logic [2:0][W-1:0] v0, v1, v2, p_hit, normal;
  logic [7:0]      in_tag;

  logic            in_ready_a, out_valid_a, out_hit_a;
  logic [2:0]      out_edge_a;
  logic [7:0]      out_tag_a;
  logic            in_ready_b, out_valid_b, out_hit_b;
  logic [2:0]      out_edge_b;
  logic [7:0]      out_tag_b;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  tri_hit_pipe #(.WIDTH(32), .FRAC(16), .TAG_W(8), .INCLUSIVE(1'b0), .TWO_SIDED(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .v0(v0), .v1(v1), .v2(v2), .p_hit(p_hit), .normal(normal), .in_tag(in_tag),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_hit(out_hit_a),
    .out_edge(out_edge_a), .out_tag(out_tag_a)
  );

  tri_hit_pipe #(.WIDTH(32), .FRAC(16), .TAG_W(8), .INCLUSIVE(1'b1), .TWO_SIDED(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .v0(v0), .v1(v1), .v2(v2), .p_hit(p_hit), .normal(normal), .in_tag(in_tag),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_hit(out_hit_b),
    .out_edge(out_edge_b), .out_tag(out_tag_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0][W-1:0] pt(input logic [W-1:0] x, input logic [W-1:0] y);
    return {32'd0, y, x};
  endfunction

  task automatic set_tri(input bit cw);
    v0     = pt(32'd0, 32'd0);
    v1     = cw ? pt(32'd0, ONE) : pt(ONE, 32'd0);
    v2     = cw ? pt(ONE, 32'd0) : pt(32'd0, ONE);
    normal = {ONE, 32'd0, 32'd0};
  endtask

  // One isolated test: drive, confirm no early result, then check the result 5 cycles on
  task automatic run_test(input logic [7:0] tag, input logic [W-1:0] px, input logic [W-1:0] py,
                          input logic ha, input logic [2:0] ea, input logic hb, input logic [2:0] eb);
    @(negedge clk);
    p_hit    = pt(px, py);
    in_tag   = tag;
    in_valid = 1'b1;
    #1 chk("t_in_ready", 32'(in_ready_a), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    p_hit    = pt($urandom, $urandom);
    in_tag   = 8'($urandom);
    chk("t_lat1", 32'(out_valid_a), 32'd0);
    for (int k = 2; k < 5; k++) begin
      @(negedge clk);
      chk("t_lat_early", 32'(out_valid_a), 32'd0);
    end
    @(negedge clk);
    chk("t_valid_a", 32'(out_valid_a), 32'd1);
    chk("t_valid_b", 32'(out_valid_b), 32'd1);
    chk("t_tag_a", 32'(out_tag_a), 32'(tag));
    chk("t_tag_b", 32'(out_tag_b), 32'(tag));
    chk("t_hit_a", 32'(out_hit_a), 32'(ha));
    chk("t_edge_a", 32'(out_edge_a), 32'(ea));
    chk("t_hit_b", 32'(out_hit_b), 32'(hb));
    chk("t_edge_b", 32'(out_edge_b), 32'(eb));
  endtask

  initial begin
    int  sent;
    int  got;
    int  cyc;
    bit  acc;
    logic       exp_hit;
    logic [2:0] exp_edge;

    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_tag    = 8'h00;
    p_hit     = '0;
    set_tri(1'b0);

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid_a), 32'd0);
    chk("rst_hit", 32'(out_hit_a), 32'd0);
    chk("rst_edge", 32'(out_edge_a), 32'd0);
    chk("rst_tag", 32'(out_tag_a), 32'd0);
    chk("rst_in_ready", 32'(in_ready_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready_a), 32'd1);

    // Counter-clockwise unit triangle in z=0, normal +z
    run_test(8'h11, QTR, QTR, 1'b1, 3'b111, 1'b1, 3'b111);
    run_test(8'h22, ONE, ONE, 1'b0, 3'b101, 1'b0, 3'b101);
    run_test(8'h33, HALF, 32'd0, 1'b0, 3'b110, 1'b1, 3'b111);
    // Clockwise winding: all checks negative
    set_tri(1'b1);
    run_test(8'h44, QTR, QTR, 1'b0, 3'b000, 1'b1, 3'b000);
    set_tri(1'b0);

    // Eight back-to-back tests with a 3-cycle downstream stall
    sent = 0;
    got  = 0;
    cyc  = 0;
    acc  = 1'b0;
    while (got < 8 && cyc < 60) begin
      @(negedge clk);
      if (acc) sent++;
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (sent < 8) begin
        in_valid = 1'b1;
        in_tag   = 8'(sent);
        p_hit    = sent[0] ? pt(ONE, ONE) : pt(QTR, QTR);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      acc = in_valid && in_ready_a;
      if (out_valid_a) begin
        exp_hit  = !got[0];
        exp_edge = got[0] ? 3'b101 : 3'b111;
        chk("s_tag_a", 32'(out_tag_a), 32'(got));
        chk("s_tag_b", 32'(out_tag_b), 32'(got));
        chk("s_hit_a", 32'(out_hit_a), 32'(exp_hit));
        chk("s_edge_a", 32'(out_edge_a), 32'(exp_edge));
        chk("s_hit_b", 32'(out_hit_b), 32'(exp_hit));
        chk("s_edge_b", 32'(out_edge_b), 32'(exp_edge));
        if (!out_ready) begin
          chk("s_stall_in_ready_a", 32'(in_ready_a), 32'd0);
          chk("s_stall_in_ready_b", 32'(in_ready_b), 32'd0);
        end else begin
          got++;
        end
      end
      cyc++;
    end
    chk("s_delivered", 32'(got), 32'd8);
    chk("s_sent", 32'(sent), 32'd8);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(negedge clk);
    chk("s_no_extra", 32'(out_valid_a), 32'd0);

    // Reset with three tests in flight
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_tag   = 8'(8'hA1 + k);
      p_hit    = pt(QTR, QTR);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("r_first_valid", 32'(out_valid_a), 32'd1);
    chk("r_first_tag", 32'(out_tag_a), 32'hA1);
    rst_n = 1'b0;
    #1;
    chk("r_valid_a", 32'(out_valid_a), 32'd0);
    chk("r_valid_b", 32'(out_valid_b), 32'd0);
    chk("r_hit", 32'(out_hit_a), 32'd0);
    chk("r_edge", 32'(out_edge_a), 32'd0);
    chk("r_tag", 32'(out_tag_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) chk("r_in_ready", 32'(in_ready_a), 32'd1);
      chk("r_no_ghost_a", 32'(out_valid_a), 32'd0);
      chk("r_no_ghost_b", 32'(out_valid_b), 32'd0);
    end
    run_test(8'h5C, QTR, QTR, 1'b1, 3'b111, 1'b1, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
